// File: rtl/protocol_framer.sv
// Transmit framer: emits AA 55 CMD LEN_H LEN_L PAYLOAD CHECKSUM per accepted request over valid/ready.
// Optional stall abort is compiled in when PROTOCOL_FRAMER_TIMEOUT_EN is defined.
module protocol_framer #(
  parameter int MAX_PAYLOAD_LEN = 256,
  parameter int ADDR_WIDTH      = $clog2(MAX_PAYLOAD_LEN),
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            cmd_in,
  input  logic [15:0]           len_in,
  output logic [ADDR_WIDTH-1:0] payload_rd_addr,
  input  logic [7:0]            payload_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF1, S_SOF2, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHECKSUM
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cmd;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [7:0]  r_csum;
  logic        r_done;
  logic        r_error;
  logic        w_valid;
  logic        w_xfer;
  logic        w_accept;
  logic        w_reject;
  logic        w_timeout;
  logic        w_last_pl;

  assign w_valid   = (r_state != S_IDLE);
  assign w_xfer    = w_valid && tx_ready;
  assign w_last_pl = (r_cnt == r_len - 16'd1);

  assign tx_valid        = w_valid;
  assign busy            = w_valid;
  assign done            = r_done;
  assign error           = r_error;
  assign payload_rd_addr = r_cnt[ADDR_WIDTH-1:0];

`ifdef PROTOCOL_FRAMER_TIMEOUT_EN
  // Counter holds the number of consecutive stalled cycles already seen.
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [STALL_W-1:0] r_stall;
  logic               w_stall;

  assign w_stall   = w_valid && !tx_ready;
  assign w_timeout = w_stall && (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_stall || w_timeout) r_stall <= '0;
    else                              r_stall <= r_stall + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    tx_data     = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if ({16'd0, len_in} > 32'(MAX_PAYLOAD_LEN)) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_SOF1;
          end
        end
      end
      S_SOF1: begin
        tx_data = 8'hAA;
        if (w_xfer) w_state_nxt = S_SOF2;
      end
      S_SOF2: begin
        tx_data = 8'h55;
        if (w_xfer) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        tx_data = r_cmd;
        if (w_xfer) w_state_nxt = S_LEN_H;
      end
      S_LEN_H: begin
        tx_data = r_len[15:8];
        if (w_xfer) w_state_nxt = S_LEN_L;
      end
      S_LEN_L: begin
        tx_data = r_len[7:0];
        if (w_xfer) w_state_nxt = (r_len != 16'd0) ? S_PAYLOAD : S_CHECKSUM;
      end
      S_PAYLOAD: begin
        tx_data = payload_rd_data;
        if (w_xfer && w_last_pl) w_state_nxt = S_CHECKSUM;
      end
      S_CHECKSUM: begin
        tx_data = r_csum;
        if (w_xfer) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  // Checksum covers CMD, LEN and payload; the byte added is exactly the one on tx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 16'd0;
      r_csum  <= 8'h00;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= w_xfer && (r_state == S_CHECKSUM);
      r_error <= w_reject || w_timeout;
      if (w_accept) begin
        r_cnt  <= 16'd0;
        r_csum <= 8'h00;
      end else if (w_xfer) begin
        if (r_state inside {S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD}) r_csum <= r_csum + tx_data;
        if (r_state == S_PAYLOAD) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd <= cmd_in;
      r_len <= len_in;
    end
  end

endmodule

// File: tb/tb_protocol_framer.sv
// Randomized bench for protocol_framer: a queue-based frame model predicts every output each cycle.
// Timeout scenario runs only when PROTOCOL_FRAMER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_protocol_framer;

  localparam int MAXL = 256;
  localparam int TO   = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        last;
    logic        pl;
    logic [15:0] idx;
    logic [7:0]  data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd_in = 8'h00;
  logic [15:0] len_in = 16'h0000;
  logic [7:0]  payload_rd_addr;
  logic [7:0]  payload_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0] mem [256];
  assign payload_rd_data = mem[payload_rd_addr];

  protocol_framer #(.MAX_PAYLOAD_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_in(cmd_in), .len_in(len_in),
    .payload_rd_addr(payload_rd_addr), .payload_rd_data(payload_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   rdy_mode = 0;
  int   zero_run = 0;
  int   stall_n = 0;
  int   done_cyc[$];
  ent_t exp_q[$];
  bq_t  cap_q;
  bq_t  mon_b;
  ent_t mon_e;
  logic done_due = 1'b0;
  logic err_due = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic mb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference frame built straight from the format rules.
  function automatic void build(input logic [7:0] c, input logic [15:0] l, output bq_t q);
    int sum;
    q = {};
    q.push_back(8'hAA);
    q.push_back(8'h55);
    q.push_back(c);
    q.push_back(l[15:8]);
    q.push_back(l[7:0]);
    sum = int'(c) + int'(l[15:8]) + int'(l[7:0]);
    for (int i = 0; i < int'(l); i++) begin
      q.push_back(mem[i[7:0]]);
      sum += int'(mem[i[7:0]]);
    end
    q.push_back(8'(sum % 256));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready driver: 0 always-ready, 1 random with bounded stall streaks, 2 never-ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        tx_ready = (zero_run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        zero_run = tx_ready ? 0 : zero_run + 1;
      end else begin
        tx_ready = (rdy_mode == 0);
        zero_run = 0;
      end
    end
  end

  // Compare process: check this cycle against the model, then advance the model.
  always @(negedge clk) begin
    mb = (exp_q.size() != 0);
    chk("done", done, done_due);
    chk("error", error, err_due);
    chk("tx_valid", tx_valid, mb);
    chk("busy", busy, mb);
    if (!mb) chk("tx_data_idle", tx_data, 0);
    else begin
      chk("tx_data", tx_data, exp_q[0].data);
      if (exp_q[0].pl) chk("rd_addr", payload_rd_addr, exp_q[0].idx[7:0]);
    end
    if (prev_stall) chk("stall_stable", tx_data, prev_data);
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (error) err_cnt++;
    done_due = 1'b0;
    err_due  = 1'b0;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      stall_n = 0;
    end else begin
      if (mb && tx_ready) begin
        mon_e = exp_q.pop_front();
        cap_q.push_back(mon_e.data);
        done_due = mon_e.last;
        stall_n = 0;
      end else if (mb) begin
        stall_n++;
`ifdef PROTOCOL_FRAMER_TIMEOUT_EN
        if (stall_n == TO) begin
          exp_q.delete();
          err_due = 1'b1;
          stall_n = 0;
        end
`endif
      end else begin
        stall_n = 0;
      end
      if (!mb && start) begin
        if (int'(len_in) > MAXL) err_due = 1'b1;
        else begin
          build(cmd_in, len_in, mon_b);
          for (int k = 0; k < mon_b.size(); k++) begin
            mon_e.data = mon_b[k];
            mon_e.last = (k == mon_b.size() - 1);
            mon_e.pl   = (k >= 5) && (k < mon_b.size() - 1);
            mon_e.idx  = 16'(k - 5);
            exp_q.push_back(mon_e);
          end
        end
      end
      prev_stall = mb && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [15:0] l, input int mode, input bit poke);
    int d0;
    int i;
    d0 = done_cnt;
    cap_q.delete();
    rdy_mode = mode;
    start = 1'b1;
    cmd_in = c;
    len_in = l;
    tick();
    start = 1'b0;
    i = 0;
    while (exp_q.size() != 0 && i < 4000) begin
      if (l == 16'd0) chk("addr_empty", payload_rd_addr, 0);
      if (poke && i == 2) begin
        start = 1'b1; cmd_in = 8'hEE; len_in = 16'd1;
      end else if (poke && i == 3) begin
        start = 1'b0; cmd_in = c; len_in = l;
      end
      tick();
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("frame_complete", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
    chk("done_count", done_cnt - d0, 1);
    chk("frame_bytes", cap_q.size(), int'(l) + 6);
    rdy_mode = 0;
    tick();
  endtask

  task automatic reject(input logic [15:0] l);
    int e0;
    e0 = err_cnt;
    cap_q.delete();
    start = 1'b1;
    cmd_in = 8'h77;
    len_in = l;
    tick();
    start = 1'b0;
    chk("reject_error", error, 1);
    chk("reject_valid", tx_valid, 0);
    repeat (4) tick();
    chk("reject_err_once", err_cnt - e0, 1);
    chk("reject_no_bytes", cap_q.size(), 0);
  endtask

  bq_t  mq;
  logic [7:0] basic_exp [8];
  logic [7:0] empty_exp [6];
  int d0;
  int e0;
  int i;

  initial begin
    basic_exp = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'h10, 8'h20, 8'h33};
    empty_exp = '{8'hAA, 8'h55, 8'h05, 8'h00, 8'h00, 8'h05};
    fill_mem();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_addr", payload_rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);

    // Pin the model with hand-computed frames.
    mem[0] = 8'h10; mem[1] = 8'h20;
    build(8'h01, 16'd2, mq);
    chk("model_basic_len", mq.size(), 8);
    for (int k = 0; k < 8; k++) chk("model_basic_byte", mq[k], basic_exp[k]);
    build(8'h05, 16'd0, mq);
    chk("model_empty_csum", mq[5], 8'h05);
    mem[0] = 8'h02;
    build(8'hFF, 16'd1, mq);
    chk("model_wrap_csum", mq[6], 8'h02);

    // Basic frame, full throughput
    mem[0] = 8'h10; mem[1] = 8'h20;
    run_frame(8'h01, 16'd2, 0, 1'b0);
    for (int k = 0; k < 8; k++) chk("basic_byte", cap_q[k], basic_exp[k]);

    // Basic frame under backpressure with ignored start pulses
    run_frame(8'h01, 16'd2, 1, 1'b1);
    for (int k = 0; k < 8; k++) chk("bp_byte", cap_q[k], basic_exp[k]);

    run_frame(8'h05, 16'd0, 0, 1'b0);
    for (int k = 0; k < 6; k++) chk("empty_byte", cap_q[k], empty_exp[k]);

    mem[0] = 8'h02;
    run_frame(8'hFF, 16'd1, 0, 1'b0);
    chk("wrap_csum", cap_q[6], 8'h02);

    fill_mem();
    run_frame(8'h9C, 16'd256, 0, 1'b0);
    reject(16'd257);
    reject(16'hFFFF);

    for (int f = 0; f < 12; f++) begin
      fill_mem();
      run_frame(8'($urandom), 16'($urandom_range(0, 40)), f % 2, f[2]);
    end

    // Back-to-back: start held high is re-accepted in the done cycle
    fill_mem();
    rdy_mode = 0;
    d0 = done_cnt;
    start = 1'b1; cmd_in = 8'h33; len_in = 16'd3;
    i = 0;
    while (done_cnt < d0 + 1 && i < 100) begin tick(); i++; end
    start = 1'b0;
    i = 0;
    while (done_cnt < d0 + 2 && i < 100) begin tick(); i++; end
    chk("b2b_done_count", done_cnt - d0, 2);
    if (done_cnt >= d0 + 2) chk("b2b_spacing", done_cyc[d0 + 1] - done_cyc[d0], 10);
    repeat (2) tick();

    // Reset during PAYLOAD
    fill_mem();
    start = 1'b1; cmd_in = 8'h42; len_in = 16'd20;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_addr", payload_rd_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    run_frame(8'h42, 16'd20, 1, 1'b0);

`ifdef PROTOCOL_FRAMER_TIMEOUT_EN
    d0 = done_cnt;
    e0 = err_cnt;
    start = 1'b1; cmd_in = 8'h21; len_in = 16'd4;
    tick();
    start = 1'b0;
    tick();
    rdy_mode = 2;
    repeat (20) tick();
    chk("to_error_once", err_cnt - e0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_tx_valid", tx_valid, 0);
    chk("to_busy", busy, 0);
    rdy_mode = 0;
    repeat (2) tick();
    run_frame(8'h21, 16'd4, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
